// File: rtl/ca_row_stepper.sv
// Streaming next-generation engine for a 2-D cellular automaton, one row per beat.
// Optional frame population counter is built when CA_POPCOUNT_EN is defined.
module ca_row_stepper #(
  parameter int BOARD_WIDTH  = 32,
  parameter int BOARD_HEIGHT = 32,
  parameter int WRAP_X       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8:0]             birth_mask,
  input  logic [8:0]             survive_mask,
  input  logic [BOARD_WIDTH-1:0] s_row,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [BOARD_WIDTH-1:0] m_row,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last
`ifdef CA_POPCOUNT_EN
  ,
  output logic [$clog2(BOARD_WIDTH*BOARD_HEIGHT+1)-1:0] pop_count,
  output logic                   pop_valid
`endif
);

  localparam int W  = BOARD_WIDTH;
  localparam int CW = $clog2(BOARD_HEIGHT + 1);

  typedef enum logic [1:0] {
    S_FIRST,
    S_STREAM,
    S_FLUSH
  } state_t;

  state_t        state;
  logic [W-1:0]  prev;
  logic [W-1:0]  cur;
  logic [CW-1:0] cnt;
  logic [8:0]    bm_q;
  logic [8:0]    sm_q;

  logic          slot_free;
  logic [W-1:0]  bot;
  logic [W-1:0]  nxt;
  logic [W-1:0]  pw, pe, cw, ce, bw, be;

  assign slot_free = !m_valid || m_ready;
  assign s_ready   = (state == S_FIRST) ||
                     (state == S_STREAM && slot_free);

  // Flushing the last row sees a dead row below it.
  assign bot = (state == S_FLUSH) ? '0 : s_row;

  // xw[i] is the west neighbour of column i, xe[i] the east one.
  assign pw = {prev[W-2:0], (WRAP_X != 0) ? prev[W-1] : 1'b0};
  assign pe = {(WRAP_X != 0) ? prev[0] : 1'b0, prev[W-1:1]};
  assign cw = {cur[W-2:0], (WRAP_X != 0) ? cur[W-1] : 1'b0};
  assign ce = {(WRAP_X != 0) ? cur[0] : 1'b0, cur[W-1:1]};
  assign bw = {bot[W-2:0], (WRAP_X != 0) ? bot[W-1] : 1'b0};
  assign be = {(WRAP_X != 0) ? bot[0] : 1'b0, bot[W-1:1]};

  for (genvar i = 0; i < W; i++) begin : g_cell
    logic [3:0] n;
    assign n = 4'(pw[i]) + 4'(prev[i]) + 4'(pe[i]) +
               4'(cw[i]) + 4'(ce[i]) +
               4'(bw[i]) + 4'(bot[i]) + 4'(be[i]);
    assign nxt[i] = cur[i] ? sm_q[n] : bm_q[n];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FIRST;
      prev    <= '0;
      cur     <= '0;
      cnt     <= '0;
      bm_q    <= '0;
      sm_q    <= '0;
      m_row   <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else begin
      if (m_valid && m_ready) m_valid <= 1'b0;
      unique case (state)
        S_FIRST: begin
          if (s_valid) begin
            prev  <= '0;
            cur   <= s_row;
            cnt   <= CW'(1);
            bm_q  <= birth_mask;
            sm_q  <= survive_mask;
            state <= (BOARD_HEIGHT == 1) ? S_FLUSH : S_STREAM;
          end
        end
        S_STREAM: begin
          if (s_valid && slot_free) begin
            m_row   <= nxt;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            prev    <= cur;
            cur     <= s_row;
            cnt     <= cnt + CW'(1);
            if (cnt == CW'(BOARD_HEIGHT - 1)) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (slot_free) begin
            m_row   <= nxt;
            m_valid <= 1'b1;
            m_last  <= 1'b1;
            state   <= S_FIRST;
          end
        end
        default: state <= S_FIRST;
      endcase
    end
  end

`ifdef CA_POPCOUNT_EN
  localparam int PW = $clog2(BOARD_WIDTH*BOARD_HEIGHT+1);

  logic [PW-1:0] acc;
  logic [PW-1:0] ones;

  assign ones = PW'($countones(m_row));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      pop_count <= '0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      if (m_valid && m_ready) begin
        if (m_last) begin
          pop_count <= acc + ones;
          pop_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= acc + ones;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ca_row_stepper.sv
// Scoreboard bench for ca_row_stepper: 5x5 engine plus two 8x3 engines
// differing only in horizontal wrap.
module tb_ca_row_stepper;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] bm, sm;

  logic [4:0] s_row;
  logic       s_valid;
  logic       s_ready;
  logic [4:0] m_row;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  logic [7:0] s_row8;
  logic       s_valid8;
  logic       m_ready8;
  logic       s_ready_w1, s_ready_w0;
  logic [7:0] m_row_w1, m_row_w0;
  logic       m_valid_w1, m_valid_w0;
  logic       m_last_w1, m_last_w0;

`ifdef CA_POPCOUNT_EN
  logic [4:0] pop_count, pop_count_w1, pop_count_w0;
  logic       pop_valid, pop_valid_w1, pop_valid_w0;
  int         popq[$];
`endif

  int checks   = 0;
  int failures = 0;
  int out_cnt  = 0;
  int stall_at = 6;

  logic [5:0] q[$];
  logic [8:0] q1[$];
  logic [8:0] q0[$];

  always #5 clk = ~clk;

  ca_row_stepper #(
    .BOARD_WIDTH(5), .BOARD_HEIGHT(5), .WRAP_X(0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .birth_mask(bm), .survive_mask(sm),
    .s_row(s_row), .s_valid(s_valid), .s_ready(s_ready),
    .m_row(m_row), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last)
`ifdef CA_POPCOUNT_EN
    , .pop_count(pop_count), .pop_valid(pop_valid)
`endif
  );

  ca_row_stepper #(
    .BOARD_WIDTH(8), .BOARD_HEIGHT(3), .WRAP_X(1)
  ) u_w1 (
    .clk(clk), .rst(rst),
    .birth_mask(bm), .survive_mask(sm),
    .s_row(s_row8), .s_valid(s_valid8), .s_ready(s_ready_w1),
    .m_row(m_row_w1), .m_valid(m_valid_w1), .m_ready(m_ready8),
    .m_last(m_last_w1)
`ifdef CA_POPCOUNT_EN
    , .pop_count(pop_count_w1), .pop_valid(pop_valid_w1)
`endif
  );

  ca_row_stepper #(
    .BOARD_WIDTH(8), .BOARD_HEIGHT(3), .WRAP_X(0)
  ) u_w0 (
    .clk(clk), .rst(rst),
    .birth_mask(bm), .survive_mask(sm),
    .s_row(s_row8), .s_valid(s_valid8), .s_ready(s_ready_w0),
    .m_row(m_row_w0), .m_valid(m_valid_w0), .m_ready(m_ready8),
    .m_last(m_last_w0)
`ifdef CA_POPCOUNT_EN
    , .pop_count(pop_count_w0), .pop_valid(pop_valid_w0)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [4:0] r);
    int k;
    k = 0;
    s_row   = r;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (s_ready) break;
      k++;
      if (k > 200) begin
        chk("s_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_row   = '0;
  endtask

  task automatic send8(input logic [7:0] r);
    int k;
    k = 0;
    s_row8   = r;
    s_valid8 = 1'b1;
    forever begin
      @(negedge clk);
      #1;
      if (s_ready_w1 && s_ready_w0) break;
      k++;
      if (k > 200) begin
        chk("s_ready8_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid8 = 1'b0;
    s_row8   = '0;
  endtask

  task automatic frame(input logic [4:0] rows[5],
                       input logic [4:0] outs[5],
                       input int pop,
                       input bit flip);
    for (int i = 0; i < 5; i++) q.push_back({i == 4, outs[i]});
`ifdef CA_POPCOUNT_EN
    popq.push_back(pop);
`else
    if (pop < 0) $display("note: bad pop %0d", pop);
`endif
    for (int i = 0; i < 5; i++) begin
      send(rows[i]);
      if (flip && i == 1) begin
        bm = ~bm;
        sm = ~sm;
      end
    end
  endtask

  function automatic int pending();
    int n;
    n = q.size() + q1.size() + q0.size();
`ifdef CA_POPCOUNT_EN
    n += popq.size();
`endif
    return n;
  endfunction

  task automatic drain();
    int k;
    k = 0;
    while (pending() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain", pending(), 0);
  endtask

  // Main scoreboard, with a one-off 4-cycle stall on output index stall_at.
  always begin
    logic [5:0] e;
    @(negedge clk);
    if (m_valid && !rst) begin
      if (out_cnt == stall_at) begin
        stall_at = -1;
        m_ready  = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("hold_valid", m_valid, 1);
          chk("hold_row", m_row, (q.size() > 0) ? q[0][4:0] : 5'h1f);
          chk("stall_s_ready", s_ready, 0);
        end
        m_ready = 1'b1;
      end
      if (m_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("m_row", m_row, e[4:0]);
          chk("m_last", m_last, e[5]);
        end
        out_cnt++;
      end
    end
  end

  always begin
    logic [8:0] e;
    @(negedge clk);
    if (!rst && m_valid_w1) begin
      if (q1.size() == 0) chk("spurious_w1", 1, 0);
      else begin
        e = q1.pop_front();
        chk("w1_row", m_row_w1, e[7:0]);
        chk("w1_last", m_last_w1, e[8]);
      end
    end
    if (!rst && m_valid_w0) begin
      if (q0.size() == 0) chk("spurious_w0", 1, 0);
      else begin
        e = q0.pop_front();
        chk("w0_row", m_row_w0, e[7:0]);
        chk("w0_last", m_last_w0, e[8]);
      end
    end
  end

`ifdef CA_POPCOUNT_EN
  always begin
    @(negedge clk);
    if (!rst && pop_valid) begin
      if (popq.size() == 0) chk("spurious_pop", 1, 0);
      else chk("pop_count", pop_count, popq.pop_front());
    end
  end
`endif

  initial begin
    logic [4:0] t1_in[5];
    logic [4:0] t1_out[5];
    logic [4:0] t4_in[5];
    logic [4:0] t4_out[5];
    logic [7:0] w_in[3];

    t1_in  = '{5'h00, 5'h0E, 5'h00, 5'h00, 5'h00};
    t1_out = '{5'h04, 5'h04, 5'h04, 5'h00, 5'h00};
    t4_in  = '{5'h00, 5'h00, 5'h04, 5'h00, 5'h00};
    t4_out = '{5'h00, 5'h0E, 5'h0A, 5'h0E, 5'h00};
    w_in   = '{8'h00, 8'h83, 8'h00};

    rst      = 1'b1;
    bm       = 9'h008;
    sm       = 9'h00C;
    s_row    = '0;
    s_valid  = 1'b0;
    m_ready  = 1'b1;
    s_row8   = '0;
    s_valid8 = 1'b0;
    m_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_row", m_row, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_s_ready", s_ready, 1);
`ifdef CA_POPCOUNT_EN
    chk("rst_pop_count", pop_count, 0);
    chk("rst_pop_valid", pop_valid, 0);
`endif

    // Blinker, then the same frame back-to-back with a stall on its row 1.
    frame(t1_in, t1_out, 3, 1'b0);
    frame(t1_in, t1_out, 3, 1'b0);
    drain();

    bm = 9'h002;
    sm = 9'h000;
    frame(t4_in, t4_out, 8, 1'b1);
    drain();
    bm = 9'h008;
    sm = 9'h00C;

    // Reset after two rows: nothing from the partial frame may appear.
    send(5'h00);
    send(5'h0E);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_s_ready", s_ready, 1);
    frame(t1_in, t1_out, 3, 1'b0);
    drain();

    q1.push_back({1'b0, 8'h01});
    q1.push_back({1'b0, 8'h01});
    q1.push_back({1'b1, 8'h01});
    q0.push_back({1'b0, 8'h00});
    q0.push_back({1'b0, 8'h00});
    q0.push_back({1'b1, 8'h00});
    for (int i = 0; i < 3; i++) send8(w_in[i]);
    drain();

    chk("out_count", out_cnt, 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
